// File: rtl/counter_wrap_monitor_pkg.sv
// counter_monitor_pkg: event kinds and shared widths for the counter wrap monitor
package counter_monitor_pkg;
    typedef enum logic [1:0] {
        KIND_NONE   = 2'b00,
        KIND_WRAP   = 2'b01,
        KIND_RESET  = 2'b10,
        KIND_GLITCH = 2'b11
    } evt_kind_e;
    localparam int WRAP_TOTAL_W = 8;
endpackage

// File: rtl/counter_wrap_monitor_if.sv
// counter_wrap_monitor_if: valid/ready event stream from the monitor to its consumer
interface counter_wrap_monitor_if
    import counter_monitor_pkg::*;
#(
    parameter int StampWidth = 16
);
    logic                  evt_valid;
    logic                  evt_ready;
    evt_kind_e             evt_kind;
    logic [StampWidth-1:0] evt_stamp;
    modport master (output evt_valid, output evt_kind, output evt_stamp, input evt_ready);
    modport slave  (input evt_valid, input evt_kind, input evt_stamp, output evt_ready);
endinterface

// File: rtl/counter_event_fifo.sv
// counter_event_fifo: synchronous FIFO that accepts a push on a full edge when a pop frees a slot
module counter_event_fifo #(
    parameter int Width = 18,
    parameter int Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(Depth);
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [Width-1:0] r_mem [Depth];
    logic             w_push;
    logic             w_pop;
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    // Pointers advance on accepted push/pop; reset empties the queue
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    // Storage needs no reset: empty masks the head
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/counter_wrap_monitor.sv
// counter_wrap_monitor: classifies count transitions and queues timestamped wrap/reset/glitch events
module counter_wrap_monitor
    import counter_monitor_pkg::*;
#(
    parameter int Size       = 5,
    parameter int Depth      = 4,
    parameter int StampWidth = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [Size-1:0]           count,
    input  logic                      enable,
    counter_wrap_monitor_if.master    evt,
    output logic [WRAP_TOTAL_W-1:0]   wrap_total,
    output logic                      overflow
);
    localparam logic [Size-1:0] MAX = '1;
    logic [Size-1:0]       r_prev;
    logic                  r_prev_valid;
    logic [StampWidth-1:0] r_stamp;
    logic [WRAP_TOTAL_W-1:0] r_wrap_total;
    logic                  r_overflow;
    evt_kind_e             w_kind;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [StampWidth+1:0] w_head;
    // Classify the transition from the previous sample to the current count
    always_comb begin
        w_kind = KIND_NONE;
        if (enable && r_prev_valid)
            w_kind = (r_prev == MAX && count == '0) ? KIND_WRAP :
                     (count == r_prev || count == r_prev + 1'b1) ? KIND_NONE :
                     (count == '0) ? KIND_RESET : KIND_GLITCH;
    end
    assign w_push = w_kind != KIND_NONE;
    assign w_pop  = evt.evt_valid && evt.evt_ready;
    counter_event_fifo #(
        .Width (StampWidth + 2),
        .Depth (Depth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_kind, r_stamp}),
        .i_pop   (evt.evt_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    assign evt.evt_valid = !w_empty;
    assign evt.evt_kind  = evt_kind_e'(w_head[StampWidth+1:StampWidth]);
    assign evt.evt_stamp = w_head[StampWidth-1:0];
    assign wrap_total    = r_wrap_total;
    assign overflow      = r_overflow;
    // Free-running cycle stamp; an event carries the value held before its edge
    always_ff @(posedge clock) begin
        if (!reset) r_stamp <= '0;
        else r_stamp <= r_stamp + 1'b1;
    end
    // Previous-sample tracking; disabling drops the history so re-enable re-primes
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev       <= enable ? count : r_prev;
            r_prev_valid <= enable;
        end
    end
    // Saturating wrap tally and sticky drop flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wrap_total <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_kind == KIND_WRAP && r_wrap_total != '1) r_wrap_total <= r_wrap_total + 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_counter_wrap_monitor.sv
// tb_counter_wrap_monitor: directed table plus hand sequences for the counter wrap monitor
module tb_counter_wrap_monitor;
    import counter_monitor_pkg::*;
    typedef struct {
        logic [4:0]  cnt;
        logic        en;
        logic        rdy;
        logic        v;
        logic [1:0]  k;
        logic [15:0] s;
        logic [7:0]  w;
        logic        o;
    } vec_t;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] count = '0;
    logic       enable = 1'b0;
    logic [7:0] wrap_total;
    logic       overflow;
    int         n_vec = 0;
    int         n_err = 0;
    vec_t       tbl[$];
    counter_wrap_monitor_if #(.StampWidth(16)) evt ();
    counter_wrap_monitor #(.Size(5), .Depth(4), .StampWidth(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .count      (count),
        .enable     (enable),
        .evt        (evt),
        .wrap_total (wrap_total),
        .overflow   (overflow)
    );
    always #5 clock = ~clock;
    function automatic void add(input int c, input int e, input int r, input int v, input int k,
                                input int s, input int w, input int o);
        vec_t x;
        x.cnt = c[4:0]; x.en = e[0]; x.rdy = r[0]; x.v = v[0];
        x.k = k[1:0]; x.s = s[15:0]; x.w = w[7:0]; x.o = o[0];
        tbl.push_back(x);
    endfunction
    task automatic tick(input logic [4:0] c, input logic e, input logic r);
        count = c;
        enable = e;
        evt.evt_ready = r;
        @(posedge clock);
        @(negedge clock);
    endtask
    task automatic check(input string name, input logic v, input logic [1:0] k, input logic [15:0] s,
                         input logic [7:0] w, input logic o);
        n_vec++;
        if ({evt.evt_valid, evt.evt_kind, evt.evt_stamp, wrap_total, overflow} !== {v, k, s, w, o}) begin
            n_err++;
            $display("FAIL %s: got valid=%0b kind=%0d stamp=%0d wraps=%0d ovf=%0b, want valid=%0b kind=%0d stamp=%0d wraps=%0d ovf=%0b",
                     name, evt.evt_valid, evt.evt_kind, evt.evt_stamp, wrap_total, overflow, v, k, s, w, o);
        end
    endtask
    task automatic check_wraps(input string name, input logic [7:0] w);
        n_vec++;
        if (wrap_total !== w) begin
            n_err++;
            $display("FAIL %s: got wrap_total=%0d, want %0d", name, wrap_total, w);
        end
    endtask
    initial begin
        evt.evt_ready = 1'b0;
        add( 7,1,0, 0,0, 0,0,0);
        add(30,0,0, 0,0, 0,0,0);
        add(30,1,0, 0,0, 0,0,0);
        add(31,1,0, 0,0, 0,0,0);
        add( 0,1,0, 1,1, 4,1,0);
        add( 1,1,0, 1,1, 4,1,0);
        add( 1,1,1, 0,0, 0,1,0);
        add(12,0,0, 0,0, 0,1,0);
        add(12,1,0, 0,0, 0,1,0);
        add(13,1,0, 0,0, 0,1,0);
        add( 0,1,0, 1,2,10,1,0);
        add( 5,1,0, 1,2,10,1,0);
        add(20,1,0, 1,2,10,1,0);
        add(20,1,1, 1,3,11,1,0);
        add(20,1,1, 1,3,12,1,0);
        add(20,1,1, 0,0, 0,1,0);
        add( 3,1,0, 1,3,16,1,0);
        add(20,1,0, 1,3,16,1,0);
        add( 3,1,0, 1,3,16,1,0);
        add(20,1,0, 1,3,16,1,0);
        add( 3,1,0, 1,3,16,1,1);
        add(20,1,1, 1,3,17,1,1);
        add(20,1,1, 1,3,18,1,1);
        add(20,1,1, 1,3,19,1,1);
        add(20,1,1, 1,3,21,1,1);
        add(20,1,1, 0,0, 0,1,1);
        add( 4,0,0, 0,0, 0,1,1);
        add( 4,1,0, 0,0, 0,1,1);
        add( 9,0,0, 0,0, 0,1,1);
        add( 9,0,0, 0,0, 0,1,1);
        add( 9,0,0, 0,0, 0,1,1);
        add( 9,1,0, 0,0, 0,1,1);
        add(10,1,0, 0,0, 0,1,1);
        for (int i = 0; i < 3; i++) tick(5'd7, 1'b1, 1'b0);
        check("reset_state", 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].cnt, tbl[i].en, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].v, tbl[i].k, tbl[i].s, tbl[i].w, tbl[i].o);
        end
        for (int i = 0; i < 300; i++) begin
            tick(5'd31, 1'b1, 1'b1);
            tick(5'd0, 1'b1, 1'b1);
            if (i == 252) check_wraps("wraps_254", 8'd254);
            if (i == 253) check_wraps("wraps_255", 8'd255);
        end
        check_wraps("wraps_saturated", 8'd255);
        tick(5'd9, 1'b1, 1'b0);
        tick(5'd2, 1'b1, 1'b0);
        reset = 1'b0;
        tick(5'd2, 1'b1, 1'b0);
        check("mid_reset_clear", 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(5'd5, 1'b1, 1'b0);
        check("reprime_no_event", 0, 0, 0, 0, 0);
        tick(5'd3, 1'b1, 1'b0);
        check("post_reset_glitch", 1, 3, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
